// File: rtl/imm_ext_pipe_if.sv
// rtl/imm_ext_pipe_if.sv - valid/ready bundle for the immediate-extension stage
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  Imm;
  logic [1:0]       EXTOp;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] ExtendedImm;

  // decode/operand-select side: offers immediates and consumes results
  modport master (
    output in_valid, Imm, EXTOp, out_ready,
    input  in_ready, out_valid, ExtendedImm
  );

  // the extension stage itself
  modport slave (
    input  in_valid, Imm, EXTOp, out_ready,
    output in_ready, out_valid, ExtendedImm
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - registered immediate extension with one-entry skid buffer
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  imm_ext_pipe_if.slave  bus
);

  localparam int PAD_W = OUT_W - IN_W;

  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             skid_valid_q;
  logic [OUT_W-1:0] skid_data_q;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext;
  logic             acc;
  logic             pop;

  // Extension of the offered immediate; captured together with EXTOp at accept
  always_comb begin
    sext = {{PAD_W{bus.Imm[IN_W-1]}}, bus.Imm};
    ext  = '0;
    unique case (bus.EXTOp)
      2'd0:    ext = {{PAD_W{1'b0}}, bus.Imm};
      2'd1:    ext = sext;
      2'd2:    ext = {bus.Imm, {PAD_W{1'b0}}};
      default: ext = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

  // in_ready comes straight from the skid flag, so no path from out_ready
  assign bus.in_ready    = ~skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.ExtendedImm = out_data_q;

  assign acc = bus.in_valid & ~skid_valid_q;
  assign pop = out_valid_q & bus.out_ready;

  // Output register plus skid: flush first, then fill, drain or park in skid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q) begin
      if (acc) begin
        out_data_q  <= ext;
        out_valid_q <= 1'b1;
      end
    end else if (pop) begin
      if (skid_valid_q) begin
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end else if (acc) begin
        out_data_q <= ext;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (acc) begin
      skid_data_q  <= ext;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - scoreboard bench for imm_ext_pipe
module tb_imm_ext_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) w ();
  imm_ext_pipe_if #(.IN_W(8),  .OUT_W(16)) n ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .bus   (w.slave)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16)) dut_n (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .bus   (n.slave)
  );

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] sb[$];
  int          tests = 0;
  int          fails = 0;
  int          pops  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] op);
    logic signed [31:0] s;
    s = $signed(imm);
    case (op)
      2'd0:    return {16'h0000, imm};
      2'd1:    return s;
      2'd2:    return {imm, 16'h0000};
      default: return s * 4;
    endcase
  endfunction

  // Called at a negedge after inputs are set; scores the coming edge, returns at next negedge
  task automatic cycle();
    logic acc, pop;
    #1;
    acc = w.in_valid & w.in_ready;
    pop = w.out_valid & w.out_ready;
    if (pop) begin
      pops++;
      if (sb.size() == 0) chk("sb_spurious_output", w.ExtendedImm, 32'hxxxxxxxx);
      else chk("sb_data", w.ExtendedImm, sb.pop_front());
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back(model_ext(w.Imm, w.EXTOp));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] op, input logic rdy);
    w.in_valid  = v;
    w.Imm       = imm;
    w.EXTOp     = op;
    w.out_ready = rdy;
  endtask

  initial begin
    vecs[0] = '{16'h8001, 2'd0, 32'h00008001};
    vecs[1] = '{16'h8001, 2'd1, 32'hFFFF8001};
    vecs[2] = '{16'h8001, 2'd2, 32'h80010000};
    vecs[3] = '{16'h8001, 2'd3, 32'hFFFE0004};

    drive(1'b0, 16'h0, 2'd0, 1'b0);
    n.in_valid = 1'b0; n.Imm = 8'h00; n.EXTOp = 2'd0; n.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, w.out_valid}, 32'd0);
    chk("rst_data", w.ExtendedImm, 32'd0);
    chk("rst_in_ready", {31'b0, w.in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // mode sweep: result visible one cycle after accept
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i].imm, vecs[i].op, 1'b1);
      cycle();
      chk("mode_valid", {31'b0, w.out_valid}, 32'd1);
      chk("mode_data", w.ExtendedImm, vecs[i].exp);
      drive(1'b0, 16'h0, 2'd0, 1'b1);
      cycle();
    end
    chk("mode_idle_valid", {31'b0, w.out_valid}, 32'd0);

    // back-to-back stream
    pops = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 2'd1, 1'b1);
      chk("b2b_in_ready", {31'b0, w.in_ready}, 32'd1);
      cycle();
      chk("b2b_out_valid", {31'b0, w.out_valid}, 32'd1);
    end
    drive(1'b0, 16'h0, 2'd1, 1'b1);
    cycle();
    chk("b2b_pop_count", pops, 32'd8);

    // stall: 10 held, 11 skidded, 12 held off
    drive(1'b1, 16'd10, 2'd1, 1'b0);
    cycle();
    chk("stall_hold10", w.ExtendedImm, 32'd10);
    chk("stall_ready1", {31'b0, w.in_ready}, 32'd1);
    drive(1'b1, 16'd11, 2'd1, 1'b0);
    cycle();
    chk("stall_hold10b", w.ExtendedImm, 32'd10);
    chk("stall_ready0", {31'b0, w.in_ready}, 32'd0);
    drive(1'b1, 16'd12, 2'd2, 1'b0);
    cycle();
    chk("stall_hold10c", w.ExtendedImm, 32'd10);
    chk("stall_ready0b", {31'b0, w.in_ready}, 32'd0);
    drive(1'b1, 16'd12, 2'd1, 1'b1);
    cycle();
    chk("stall_next11", w.ExtendedImm, 32'd11);
    chk("stall_ready_back", {31'b0, w.in_ready}, 32'd1);
    cycle();
    chk("stall_next12", w.ExtendedImm, 32'd12);
    drive(1'b0, 16'h0, 2'd1, 1'b1);
    cycle();
    chk("stall_empty", {31'b0, w.out_valid}, 32'd0);

    // flush with skid full and input offered
    drive(1'b1, 16'd20, 2'd0, 1'b0);
    cycle();
    drive(1'b1, 16'd21, 2'd0, 1'b0);
    cycle();
    drive(1'b1, 16'd22, 2'd0, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_out_valid", {31'b0, w.out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, w.in_ready}, 32'd1);
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    cycle();
    chk("flush_nothing_left", {31'b0, w.out_valid}, 32'd0);

    // flush together with pop and an accept: both dropped/consumed
    drive(1'b1, 16'd30, 2'd0, 1'b1);
    cycle();
    drive(1'b1, 16'd31, 2'd0, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    chk("flushpop_out_valid", {31'b0, w.out_valid}, 32'd0);
    cycle();
    chk("flushpop_still_empty", {31'b0, w.out_valid}, 32'd0);

    // asynchronous reset mid-stall, between edges
    drive(1'b1, 16'd40, 2'd1, 1'b0);
    cycle();
    drive(1'b1, 16'd41, 2'd1, 1'b0);
    cycle();
    drive(1'b0, 16'h0, 2'd1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, w.out_valid}, 32'd0);
    chk("arst_data", w.ExtendedImm, 32'd0);
    chk("arst_in_ready", {31'b0, w.in_ready}, 32'd1);
    sb.delete();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_resurrect", {31'b0, w.out_valid}, 32'd0);
    drive(1'b1, 16'hFFFF, 2'd3, 1'b1);
    cycle();
    chk("arst_resume", w.ExtendedImm, 32'hFFFFFFFC);
    drive(1'b0, 16'h0, 2'd0, 1'b1);
    cycle();

    // narrow parameter instance
    n.in_valid = 1'b1; n.Imm = 8'hF0; n.EXTOp = 2'd1;
    @(posedge clk); @(negedge clk);
    chk("narrow_sext", {16'h0, n.ExtendedImm}, 32'h0000FFF0);
    n.EXTOp = 2'd3;
    @(posedge clk); @(negedge clk);
    chk("narrow_br", {16'h0, n.ExtendedImm}, 32'h0000FFC0);
    n.in_valid = 1'b0;

    // bounded drain of anything still owed
    for (int k = 0; k < 20 && sb.size() > 0; k++) cycle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate-extension stage for the pipelined MIPS datapath. It extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes: zero, sign, upper-load and branch-offset. The result is held in a one-entry output register plus a one-entry skid buffer, using a valid/ready handshake. The block sits between decode and the operand-select stage, and supports pipeline stall (out_ready low) and flush.

## Interface
- IN_W, 16, immediate input width; must be ≥ 2.
- OUT_W, 32, extended output width; must be ≥ IN_W + 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all held entries.
- in_valid  input  1  producer offers Imm/EXTOp this cycle.
- in_ready  output  1  block can accept this cycle.
- Imm  input  IN_W  raw immediate.
- EXTOp  input  2  mode: 0 zero-ext, 1 sign-ext, 2 upper (Imm placed in the top IN_W bits, low bits 0), 3 sign-ext then shift left 2.
- out_valid  output  1  ExtendedImm holds a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- ExtendedImm  output  OUT_W  extended result.

## Operation
- Extension function ext(Imm, op), purely combinational on the input side:
  - op 0: {(OUT_W-IN_W){0}, Imm}.
  - op 1: {(OUT_W-IN_W){Imm[IN_W-1]}, Imm}.
  - op 2: {Imm, (OUT_W-IN_W){0}}.
  - op 3: sign-ext to OUT_W, then << 2. The top 2 bits are discarded; no overflow is possible given OUT_W ≥ IN_W+2.
- State:
  - output register (O = out_valid, data = ExtendedImm).
  - skid register (S = skid_valid, skid_data).
  - Invariant: S=1 implies O=1.
- Handshake terms:
  - in_ready = ~S, driven from a register with no combinational path from out_ready.
  - acc = in_valid & in_ready.
  - pop = O & out_ready.
- Next-state rules, evaluated in priority order each clock edge:
  - flush=1: O←0, S←0. Any input offered this cycle is dropped, even if acc=1. Data registers are don't-care.
  - O=0: if acc, then data←ext, O←1.
  - O=1, pop=1, S=1: data←skid_data, S←0, O stays 1. acc is impossible in this case.
  - O=1, pop=1, S=0: if acc, data←ext and O stays 1; otherwise O←0.
  - O=1, pop=0: if acc, then skid_data←ext, S←1. ExtendedImm is unchanged.
- ExtendedImm must stay stable while out_valid=1 and out_ready=0.
- Ordering is strict FIFO; no entry is duplicated or lost except by flush.
- EXTOp is captured with Imm at accept. Changing EXTOp afterwards has no effect on held entries.

## Timing
- Reset values (asynchronous, while reset=0):
  - out_valid 0, ExtendedImm 0.
  - skid_valid 0, skid_data 0.
  - in_ready 1.
- in_ready may be 1 during reset deassertion, but acceptance only occurs on clock edges with reset=1.
- Latency: an accept at edge N gives out_valid=1 with ExtendedImm=ext after edge N. The result is visible in cycle N+1.
- Throughput: 1 result per cycle while out_ready=1.
- Stall: while out_ready=0, at most 2 entries are held. in_ready falls to 0 in the cycle after the skid fills, and returns to 1 in the cycle after the skid drains.
- Simultaneous flush with pop: the flush wins; the popped entry counts as consumed by the consumer, and nothing remains.
- Reset asserted mid-operation: all held entries are discarded immediately, without waiting for a clock edge.

## Test plan
- Mode sweep, IN_W=16/OUT_W=32, out_ready=1: Imm=16'h8001 with op 0/1/2/3 → 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004. Each appears one cycle after its accept.
- Back-to-back stream of Imm 1..8 (op 1), out_ready=1 → 8 consecutive outputs in order. in_valid=1 and in_ready=1 every cycle.
- Stall: stream Imm 10,11,12 with out_ready=0 for 3 cycles.
  - ExtendedImm holds 10; in_ready drops to 0 after 11 is skidded; 12 is held off.
  - After out_ready=1, outputs are 10, 11, 12 in order with no gaps or duplicates.
- Flush with skid full plus in_valid=1 on the same edge → out_valid=0 and in_ready=1 next cycle. The dropped input never appears.
- Asynchronous reset pulse mid-stall, between clock edges → out_valid=0, ExtendedImm=0 and in_ready=1 immediately. Normal operation resumes on the first edge after release.
- Parameter instance IN_W=8/OUT_W=16: Imm=8'hF0, op 1 → 16'hFFF0; op 3 → 16'hFFC0.
